// File: rtl/adc_capture_ctrl.sv
// Triggered ADC acquisition sequencer: arms on start, decimates the sample stream,
// waits for a level/forced/timeout trigger, then streams a fixed-length capture to RAM.
module adc_capture_ctrl #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 10,
  parameter int AUTO_TO = 1000000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              start,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              auto_en,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [7:0]        decim,
  input  logic [ADDR_W-1:0] capture_len,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              armed,
  output logic              busy,
  output logic              done,
  output logic              auto_trig
);

  localparam int TO_W = (AUTO_TO < 2) ? 1 : $clog2(AUTO_TO + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state_r;
  logic              edge_r;
  logic [DATA_W-1:0] level_r;
  logic [7:0]        decim_r;
  logic [ADDR_W-1:0] len_r;
  logic [7:0]        dec_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [DATA_W-1:0] prev_r;
  logic              prev_vld_r;
  logic              pend_r;
  logic              auto_pend_r;
  logic [ADDR_W-1:0] addr_nxt_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              armed_r;
  logic              busy_r;
  logic              done_r;
  logic              auto_trig_r;

  logic              dec_hit_s;
  logic              level_hit_s;
  logic              to_hit_s;
  logic              trig_s;

  // Decimation strobe and trigger qualification for the current cycle
  always_comb begin
    dec_hit_s   = 1'b0;
    level_hit_s = 1'b0;
    to_hit_s    = 1'b0;
    trig_s      = 1'b0;
    if (sample_valid && (dec_cnt_r == 8'd0) &&
        ((state_r == WAIT_TRIG) || (state_r == CAPTURE))) begin
      dec_hit_s = 1'b1;
    end else begin
      dec_hit_s = 1'b0;
    end
    // The first decimated sample after arming only seeds prev_r
    if (!prev_vld_r) begin
      level_hit_s = 1'b0;
    end else if (edge_r) begin
      level_hit_s = (prev_r > level_r) && (sample <= level_r);
    end else begin
      level_hit_s = (prev_r < level_r) && (sample >= level_r);
    end
    if ((state_r == WAIT_TRIG) && auto_en && (to_cnt_r == TO_W'(AUTO_TO))) begin
      to_hit_s = 1'b1;
    end else begin
      to_hit_s = 1'b0;
    end
    if ((state_r == WAIT_TRIG) && dec_hit_s) begin
      trig_s = pend_r || force_trig || to_hit_s || level_hit_s;
    end else begin
      trig_s = 1'b0;
    end
  end

  // Capture sequencer with registered RAM strobe and status outputs
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r     <= IDLE;
      edge_r      <= 1'b0;
      level_r     <= {DATA_W{1'b0}};
      decim_r     <= 8'd0;
      len_r       <= {ADDR_W{1'b0}};
      dec_cnt_r   <= 8'd0;
      to_cnt_r    <= {TO_W{1'b0}};
      prev_r      <= {DATA_W{1'b0}};
      prev_vld_r  <= 1'b0;
      pend_r      <= 1'b0;
      auto_pend_r <= 1'b0;
      addr_nxt_r  <= {ADDR_W{1'b0}};
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
      armed_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      auto_trig_r <= 1'b0;
    end else if (abort) begin
      state_r     <= IDLE;
      pend_r      <= 1'b0;
      auto_pend_r <= 1'b0;
      wr_en_r     <= 1'b0;
      armed_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      auto_trig_r <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      if (sample_valid && ((state_r == WAIT_TRIG) || (state_r == CAPTURE))) begin
        dec_cnt_r <= (dec_cnt_r == decim_r) ? 8'd0 : dec_cnt_r + 8'd1;
      end
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r     <= WAIT_TRIG;
            edge_r      <= trig_edge;
            level_r     <= trig_level;
            decim_r     <= decim;
            len_r       <= capture_len;
            dec_cnt_r   <= 8'd0;
            to_cnt_r    <= {TO_W{1'b0}};
            prev_vld_r  <= 1'b0;
            pend_r      <= 1'b0;
            auto_pend_r <= 1'b0;
            armed_r     <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            auto_trig_r <= 1'b0;
          end else if (state_r == DONE) begin
            done_r <= 1'b1;
          end
        end
        WAIT_TRIG: begin
          if (auto_en && (to_cnt_r != TO_W'(AUTO_TO))) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
          if (to_hit_s) begin
            pend_r      <= 1'b1;
            auto_pend_r <= 1'b1;
          end
          if (force_trig) begin
            pend_r <= 1'b1;
          end
          if (dec_hit_s) begin
            prev_r     <= sample;
            prev_vld_r <= 1'b1;
          end
          if (trig_s) begin
            wr_en_r     <= 1'b1;
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= sample;
            addr_nxt_r  <= ADDR_W'(1);
            pend_r      <= 1'b0;
            auto_pend_r <= 1'b0;
            auto_trig_r <= auto_pend_r || to_hit_s;
            armed_r     <= 1'b0;
            if (len_r == {ADDR_W{1'b0}}) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (dec_hit_s) begin
            wr_en_r    <= 1'b1;
            wr_addr_r  <= addr_nxt_r;
            wr_data_r  <= sample;
            addr_nxt_r <= addr_nxt_r + ADDR_W'(1);
            // Last address reached: stop before the counter can wrap
            if (addr_nxt_r == len_r) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          armed_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign armed     = armed_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign auto_trig = auto_trig_r;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: each task drives one scenario and checks
// RAM writes and status against hand-computed values.
module tb_adc_capture_ctrl;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sample = 12'd0;
  logic        sample_valid = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        force_trig = 1'b0;
  logic        auto_en = 1'b0;
  logic        trig_edge = 1'b0;
  logic [11:0] trig_level = 12'd0;
  logic [7:0]  decim = 8'd0;
  logic [9:0]  capture_len = 10'd0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [11:0] wr_data;
  logic        armed;
  logic        busy;
  logic        done;
  logic        auto_trig;

  int compared = 0;
  int mismatched = 0;
  int cyc_n = 0;
  int nwr = 0;
  logic [9:0]  wa [0:1099];
  logic [11:0] wd [0:1099];
  int          wc [0:1099];

  adc_capture_ctrl #(.DATA_W(12), .ADDR_W(10), .AUTO_TO(100)) dut (
    .clk_in(clk_in), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .start(start), .abort(abort), .force_trig(force_trig), .auto_en(auto_en),
    .trig_edge(trig_edge), .trig_level(trig_level), .decim(decim),
    .capture_len(capture_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .armed(armed), .busy(busy), .done(done), .auto_trig(auto_trig)
  );

  always #5 clk_in = ~clk_in;

  // One clock: apply sample, step past the edge, log any RAM write
  task automatic cyc(input logic v, input logic [11:0] s);
    sample_valid = v;
    sample = s;
    @(posedge clk_in);
    #1;
    cyc_n++;
    if (wr_en === 1'b1) begin
      if (nwr < 1100) begin
        wa[nwr] = wr_addr;
        wd[nwr] = wr_data;
        wc[nwr] = cyc_n;
      end
      nwr++;
    end
  endtask

  task automatic arm(input logic e, input logic [11:0] lvl, input logic [7:0] dc, input logic [9:0] len);
    trig_edge = e;
    trig_level = lvl;
    decim = dc;
    capture_len = len;
    start = 1'b1;
    cyc(1'b0, 12'd0);
    start = 1'b0;
    nwr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 12'd0);
    cyc(1'b0, 12'd0);
    compared++;
    if ({wr_en, wr_addr, wr_data, armed, busy, done, auto_trig} !== 27'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h expected 0", {wr_en, wr_addr, wr_data, armed, busy, done, auto_trig});
    end
    rst = 1'b0;
    cyc(1'b0, 12'd0);
  endtask

  task automatic test_rising();
    int v;
    int done_c;
    arm(1'b0, 12'd2048, 8'd0, 10'd15);
    compared++;
    if (armed !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL rise_armed: got armed=%b busy=%b expected 1 1", armed, busy);
    end
    v = 0;
    while (done !== 1'b1 && v < 3000) begin
      cyc(1'b1, 12'(v));
      v++;
    end
    done_c = cyc_n;
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL rise_done: got %b expected 1 (timeout)", done);
    end
    compared++;
    if (nwr !== 16) begin
      mismatched++;
      $display("FAIL rise_count: got %0d expected 16", nwr);
    end
    for (int i = 0; i < 16 && i < nwr; i++) begin
      compared++;
      if (wa[i] !== 10'(i) || wd[i] !== 12'(2048 + i)) begin
        mismatched++;
        $display("FAIL rise_write[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d", i, wa[i], wd[i], i, 2048 + i);
      end
    end
    if (nwr > 0) begin
      compared++;
      if (done_c - wc[nwr-1] !== 1) begin
        mismatched++;
        $display("FAIL rise_done_lat: got %0d cycles expected 1", done_c - wc[nwr-1]);
      end
    end
    compared++;
    if (busy !== 1'b0 || armed !== 1'b0 || wr_en !== 1'b0 || auto_trig !== 1'b0) begin
      mismatched++;
      $display("FAIL rise_final: got busy=%b armed=%b wr_en=%b auto=%b expected 0 0 0 0", busy, armed, wr_en, auto_trig);
    end
  endtask

  task automatic test_decim_falling();
    int v;
    arm(1'b1, 12'd1000, 8'd3, 10'd7);
    v = 1100;
    while (done !== 1'b1 && v > 900) begin
      cyc(1'b1, 12'(v));
      v--;
    end
    compared++;
    if (done !== 1'b1 || nwr !== 8) begin
      mismatched++;
      $display("FAIL fall_count: got done=%b writes=%0d expected 1 8", done, nwr);
    end
    for (int i = 0; i < 8 && i < nwr; i++) begin
      compared++;
      if (wa[i] !== 10'(i) || wd[i] !== 12'(1000 - 4 * i)) begin
        mismatched++;
        $display("FAIL fall_write[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d", i, wa[i], wd[i], i, 1000 - 4 * i);
      end
    end
    for (int i = 1; i < 8 && i < nwr; i++) begin
      compared++;
      if (wc[i] - wc[i-1] !== 4) begin
        mismatched++;
        $display("FAIL fall_spacing[%0d]: got %0d expected 4", i, wc[i] - wc[i-1]);
      end
    end
  endtask

  task automatic test_force();
    int first_c;
    arm(1'b0, 12'd2048, 8'd1, 10'd3);
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'd500);
    compared++;
    if (nwr !== 0 || armed !== 1'b1) begin
      mismatched++;
      $display("FAIL force_pre: got writes=%0d armed=%b expected 0 1", nwr, armed);
    end
    force_trig = 1'b1;
    cyc(1'b0, 12'd500);
    force_trig = 1'b0;
    first_c = cyc_n + 1;
    for (int i = 0; i < 9; i++) cyc(1'b1, 12'd500);
    compared++;
    if (nwr !== 4) begin
      mismatched++;
      $display("FAIL force_count: got %0d expected 4", nwr);
    end
    if (nwr > 0) begin
      compared++;
      if (wc[0] !== first_c) begin
        mismatched++;
        $display("FAIL force_first: got cycle %0d expected %0d", wc[0], first_c);
      end
    end
    for (int i = 0; i < 4 && i < nwr; i++) begin
      compared++;
      if (wa[i] !== 10'(i) || wd[i] !== 12'd500) begin
        mismatched++;
        $display("FAIL force_write[%0d]: got addr=%0d data=%0d expected addr=%0d data=500", i, wa[i], wd[i], i);
      end
    end
    compared++;
    if (done !== 1'b1 || auto_trig !== 1'b0) begin
      mismatched++;
      $display("FAIL force_status: got done=%b auto=%b expected 1 0", done, auto_trig);
    end
  endtask

  task automatic test_auto();
    int t0;
    int n;
    auto_en = 1'b1;
    arm(1'b0, 12'd2048, 8'd0, 10'd1);
    t0 = cyc_n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      cyc(1'b1, 12'd700);
      n++;
    end
    auto_en = 1'b0;
    compared++;
    if (done !== 1'b1 || nwr !== 2) begin
      mismatched++;
      $display("FAIL auto_count: got done=%b writes=%0d expected 1 2", done, nwr);
    end
    if (nwr > 0) begin
      compared++;
      if (wc[0] - t0 < 100 || wc[0] - t0 > 102) begin
        mismatched++;
        $display("FAIL auto_delay: got %0d cycles expected 100..102", wc[0] - t0);
      end
    end
    compared++;
    if (auto_trig !== 1'b1) begin
      mismatched++;
      $display("FAIL auto_flag: got %b expected 1", auto_trig);
    end
  endtask

  task automatic test_rearm_reset();
    int v;
    arm(1'b0, 12'd2048, 8'd0, 10'd3);
    compared++;
    if (done !== 1'b0 || auto_trig !== 1'b0 || armed !== 1'b1) begin
      mismatched++;
      $display("FAIL rearm_clear: got done=%b auto=%b armed=%b expected 0 0 1", done, auto_trig, armed);
    end
    v = 2040;
    while (done !== 1'b1 && v < 2100) begin
      if (v == 2043) begin
        start = 1'b1;
        trig_level = 12'd4000;
      end
      cyc(1'b1, 12'(v));
      start = 1'b0;
      v++;
    end
    compared++;
    if (done !== 1'b1 || nwr !== 4) begin
      mismatched++;
      $display("FAIL rearm_count: got done=%b writes=%0d expected 1 4", done, nwr);
    end
    for (int i = 0; i < 4 && i < nwr; i++) begin
      compared++;
      if (wa[i] !== 10'(i) || wd[i] !== 12'(2048 + i)) begin
        mismatched++;
        $display("FAIL rearm_write[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d", i, wa[i], wd[i], i, 2048 + i);
      end
    end
    arm(1'b0, 12'd2048, 8'd0, 10'd31);
    v = 2044;
    while (nwr < 3 && v < 2100) begin
      cyc(1'b1, 12'(v));
      v++;
    end
    rst = 1'b1;
    cyc(1'b1, 12'(v));
    rst = 1'b0;
    compared++;
    if ({wr_en, wr_addr, wr_data, armed, busy, done, auto_trig} !== 27'd0) begin
      mismatched++;
      $display("FAIL rst_mid: got %h expected 0", {wr_en, wr_addr, wr_data, armed, busy, done, auto_trig});
    end
    for (int i = 0; i < 6; i++) cyc(1'b1, 12'(v + 1 + i));
    compared++;
    if (nwr !== 3 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_after: got writes=%0d busy=%b expected 3 0", nwr, busy);
    end
  endtask

  task automatic test_abort();
    int v;
    arm(1'b0, 12'd2048, 8'd0, 10'd31);
    v = 2040;
    while (nwr < 5 && v < 2100) begin
      cyc(1'b1, 12'(v));
      v++;
    end
    abort = 1'b1;
    cyc(1'b1, 12'(v));
    abort = 1'b0;
    compared++;
    if (wr_en !== 1'b0 || armed !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_state: got wr_en=%b armed=%b busy=%b done=%b expected 0 0 0 0", wr_en, armed, busy, done);
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, 12'(v + 1 + i));
    compared++;
    if (nwr !== 5 || wa[4] !== 10'd4) begin
      mismatched++;
      $display("FAIL abort_writes: got writes=%0d last_addr=%0d expected 5 4", nwr, wa[4]);
    end
    start = 1'b1;
    abort = 1'b1;
    cyc(1'b1, 12'd0);
    start = 1'b0;
    abort = 1'b0;
    cyc(1'b1, 12'd1);
    compared++;
    if (armed !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL start_abort: got armed=%b busy=%b expected 0 0", armed, busy);
    end
  endtask

  task automatic test_full_ram();
    int v;
    arm(1'b0, 12'd1, 8'd0, 10'd1023);
    v = 0;
    while (done !== 1'b1 && v < 1500) begin
      cyc(1'b1, 12'(v));
      v++;
    end
    compared++;
    if (done !== 1'b1 || nwr !== 1024) begin
      mismatched++;
      $display("FAIL full_count: got done=%b writes=%0d expected 1 1024", done, nwr);
    end
    for (int i = 0; i < 1024 && i < nwr; i++) begin
      compared++;
      if (wa[i] !== 10'(i) || wd[i] !== 12'(i + 1)) begin
        mismatched++;
        $display("FAIL full_write[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d", i, wa[i], wd[i], i, i + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_decim_falling();
    test_force();
    test_auto();
    test_rearm_reset();
    test_abort();
    test_full_ram();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
